apb_master_if: RTL and testbench

APB initiator: converts single commands from an internal requester (valid/ready) into APB SETUP/ACCESS transfers, waits on pready, and returns read data and error status on a response channel (valid/ready). It is the bus-side counterpart of the slave interface and drives the same APB signal set (paddr 12b, pwdata/prdata 32b, pstrb, pprot, pslverr). Used by test harnesses and by on-chip controllers that configure APB register blocks.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_timeout_cnt.sv | 30 +++
 rtl/apb_master_if.sv | 121 ++++++++++++
 tb/tb_apb_master_if.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB master constants: FSM encodings and default widths
package apb_pkg;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;
  localparam int APB_PROT_W = 3;

  // Transfer FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS-phase wait counter, flags expiry at TIMEOUT_CYCLES-1
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count not-ready ACCESS cycles; saturate at the expiry value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - APB initiator: cmd valid/ready -> SETUP/ACCESS -> rsp valid/ready (optional APB_TIMEOUT_EN)
module apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  input  logic [APB_PROT_W-1:0] cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  output logic [APB_PROT_W-1:0] pprot,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       timed_out;

`ifdef APB_TIMEOUT_EN
  logic to_expired;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (pclk),
    .rst    (prst),
    .clear  (state == ST_SETUP),
    .enable ((state == ST_ACCESS) && !pready),
    .expired(to_expired)
  );

  // pready on the expiry cycle takes priority as a normal completion
  assign timed_out = (state == ST_ACCESS) && !pready && to_expired;
`else
  assign timed_out = 1'b0;
`endif

  // Bus/handshake outputs decode straight from state so reset drops them asynchronously
  assign cmd_ready = (state == ST_IDLE) && !prst;
  assign psel      = (state == ST_SETUP) || (state == ST_ACCESS);
  assign penable   = (state == ST_ACCESS);
  assign rsp_valid = (state == ST_RESP);

  // Next-state selection for a single outstanding transfer
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cmd_valid) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (pready || timed_out) state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the command on acceptance; held untouched until the next acceptance
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      pstrb  <= '0;
      pprot  <= '0;
    end else if (state == ST_IDLE && cmd_valid) begin
      paddr  <= cmd_addr;
      pwrite <= cmd_write;
      pwdata <= cmd_write ? cmd_wdata : '0;
      pstrb  <= cmd_write ? cmd_strb : '0;
      pprot  <= cmd_prot;
    end
  end

  // Capture completion status; pslverr only counts on the ready ACCESS cycle
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ST_ACCESS) begin
      if (pready) begin
        rsp_rdata <= pwrite ? '0 : prdata;
        rsp_err   <= pslverr;
      end else if (timed_out) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_if.sv
// tb/tb_apb_master_if.sv - table-driven and randomized bench for apb_master_if
module tb_apb_master_if;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          pclk = 1'b0;
  logic          prst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            waits;
    logic [DW-1:0] prdata;
    bit            slverr;
    int            hold;
    logic [DW-1:0] exp_pwdata;
    logic [SW-1:0] exp_pstrb;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
  } vec_t;

  apb_master_if #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk(pclk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: reads carry no data/strobes, writes return zero data, error is pslverr at ready
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_pwdata = v.wr ? v.wdata : '0;
    r.exp_pstrb  = v.wr ? v.strb : '0;
    r.exp_rdata  = v.wr ? '0 : v.prdata;
    r.exp_err    = v.slverr;
    return r;
  endfunction

  // Present a command, wait for acceptance, then check the SETUP cycle; returns in ACCESS
  task automatic issue_setup(input vec_t v);
    bit ok = 0;
    cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    cmd_strb = v.strb; cmd_prot = v.prot; cmd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      if (cmd_ready) begin ok = 1; break; end
    end
    chk("cmd_accept", 32'(ok), 32'd1);
    chk("idle_psel", 32'(psel), 32'd0);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
    @(negedge pclk);
    chk("setup_psel", 32'(psel), 32'd1);
    chk("setup_penable", 32'(penable), 32'd0);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("setup_paddr", 32'(paddr), 32'(v.addr));
    chk("setup_pwrite", 32'(pwrite), 32'(v.wr));
    chk("setup_pwdata", pwdata, v.exp_pwdata);
    chk("setup_pstrb", 32'(pstrb), 32'(v.exp_pstrb));
    chk("setup_pprot", 32'(pprot), 32'(v.prot));
    @(posedge pclk); #1;
  endtask

  // Run the ACCESS phase with v.waits not-ready cycles; returns in RESP
  task automatic access(input vec_t v);
    for (int i = 0; i <= v.waits; i++) begin
      if (i == v.waits) begin
        pready = 1'b1; prdata = v.prdata; pslverr = v.slverr;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
      @(negedge pclk);
      chk("access_psel", 32'(psel), 32'd1);
      chk("access_penable", 32'(penable), 32'd1);
      chk("access_paddr_stable", 32'(paddr), 32'(v.addr));
      chk("access_pwdata_stable", pwdata, v.exp_pwdata);
      chk("access_pstrb_stable", 32'(pstrb), 32'(v.exp_pstrb));
      @(posedge pclk); #1;
    end
    pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
  endtask

  // Check the response, stalling rsp_ready for 'hold' cycles; returns in IDLE
  task automatic resp(input vec_t v);
    rsp_ready = 1'b0;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge pclk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("hold_rsp_err", 32'(rsp_err), 32'(v.exp_err));
      chk("hold_psel", 32'(psel), 32'd0);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_paddr", 32'(paddr), 32'(v.addr));
      @(posedge pclk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("rsp_psel", 32'(psel), 32'd0);
    chk("rsp_penable", 32'(penable), 32'd0);
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xfer(input vec_t v);
    issue_setup(v);
    access(v);
    resp(v);
  endtask

  vec_t tbl[5];
  vec_t a, b, r;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 12'h010, 32'h12345678, 4'hF, 3'd0, 0, 32'hCAFEF00D, 1'b0, 0,
               32'h12345678, 4'hF, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 12'h020, 32'hFFFFFFFF, 4'hF, 3'd2, 3, 32'hDEADBEEF, 1'b0, 0,
               32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 12'h044, 32'hA5A5A5A5, 4'h3, 3'd1, 1, 32'h11111111, 1'b1, 2,
               32'hA5A5A5A5, 4'h3, 32'h0, 1'b1};
    tbl[3] = '{1'b0, 12'h048, 32'h00000055, 4'hC, 3'd5, 0, 32'h0BADF00D, 1'b0, 0,
               32'h0, 4'h0, 32'h0BADF00D, 1'b0};
    tbl[4] = '{1'b0, 12'hFFC, 32'h0, 4'h1, 3'd7, 2, 32'hFFFFFFFF, 1'b1, 1,
               32'h0, 4'h0, 32'hFFFFFFFF, 1'b1};

    prst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_psel", 32'(psel), 32'd0);
    chk("reset_penable", 32'(penable), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_paddr", 32'(paddr), 32'd0);
    chk("reset_pwdata", pwdata, 32'd0);
    chk("reset_pstrb_prot_pwrite", {24'd0, pstrb, pprot, pwrite}, 32'd0);
    chk("reset_rsp", {rsp_err, rsp_rdata[30:0]} | rsp_rdata, 32'd0);
    @(posedge pclk); #1;
    prst = 1'b0;
    @(posedge pclk); #1;

    for (int i = 0; i < 5; i++) xfer(tbl[i]);

    // Response stall with the next command already waiting
    a = model('{1'b1, 12'h100, 32'h0F0F0F0F, 4'h6, 3'd3, 1, 32'h0, 1'b0, 5, '0, '0, '0, 1'b0});
    b = model('{1'b0, 12'h104, 32'h77777777, 4'hF, 3'd4, 0, 32'h89ABCDEF, 1'b0, 0, '0, '0, '0, 1'b0});
    issue_setup(a);
    access(a);
    cmd_write = b.wr; cmd_addr = b.addr; cmd_wdata = b.wdata;
    cmd_strb = b.strb; cmd_prot = b.prot; cmd_valid = 1'b1;
    resp(a);
    xfer(b);

    // Reset asserted in the middle of ACCESS
    a = model('{1'b0, 12'h200, 32'h0, 4'h0, 3'd0, 0, 32'h0, 1'b0, 0, '0, '0, '0, 1'b0});
    issue_setup(a);
    pready = 1'b0;
    @(negedge pclk);
    chk("pre_reset_penable", 32'(penable), 32'd1);
    #2 prst = 1'b1;
    #1;
    chk("async_reset_psel", 32'(psel), 32'd0);
    chk("async_reset_penable", 32'(penable), 32'd0);
    chk("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_reset_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(posedge pclk);
    #1 prst = 1'b0;
    xfer(model('{1'b0, 12'h204, 32'h0, 4'hF, 3'd6, 1, 32'h13579BDF, 1'b0, 0, '0, '0, '0, 1'b0}));

`ifdef APB_TIMEOUT_EN
    // pready never arrives: eight ACCESS cycles then error response
    a = '{1'b0, 12'h300, 32'h0, 4'h0, 3'd0, 0, 32'h0, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b1};
    issue_setup(a);
    for (int i = 0; i < 8; i++) begin
      pready = 1'b0; prdata = $urandom; pslverr = 1'b0;
      @(negedge pclk);
      chk("timeout_access_penable", 32'(penable), 32'd1);
      @(posedge pclk); #1;
    end
    resp(a);
    // pready on the eighth ACCESS cycle completes normally
    xfer(model('{1'b0, 12'h304, 32'h0, 4'h0, 3'd0, 7, 32'h2468ACE0, 1'b0, 0, '0, '0, '0, 1'b0}));
`endif

    for (int n = 0; n < 40; n++) begin
      r.wr     = 1'($urandom);
      r.addr   = AW'($urandom);
      r.wdata  = $urandom;
      r.strb   = SW'($urandom);
      r.prot   = 3'($urandom);
      r.waits  = int'($urandom_range(0, 5));
      r.prdata = $urandom;
      r.slverr = 1'($urandom);
      r.hold   = int'($urandom_range(0, 2));
      xfer(model(r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
